// File: rtl/e_mem_bot_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : e_mem_bot_ctrl_if
// Brief    : Switch-matrix request/response bundle for the bottom-east memory tile
// Revision : 1.0
// ============================================================================
interface e_mem_bot_ctrl_if;
    logic [31:0] addr0;
    logic [31:0] write_data;
    logic        req_valid;
    logic        req_we;
    logic        req_ready;
    logic [31:0] read_data;
    logic        rsp_valid;
    logic        rsp_err;
    logic        rsp_ready;
    logic        wr_err;

    modport master (
        output addr0, write_data, req_valid, req_we, rsp_ready,
        input  req_ready, read_data, rsp_valid, rsp_err, wr_err
    );

    modport slave (
        input  addr0, write_data, req_valid, req_we, rsp_ready,
        output req_ready, read_data, rsp_valid, rsp_err, wr_err
    );
endinterface
`default_nettype wire

// File: rtl/e_mem_bot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : e_mem_bot_ctrl
// Brief    : SRAM access controller with credit-guarded read-response FIFO
// Revision : 1.0
// ============================================================================
module e_mem_bot_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int RSP_DEPTH = 4
) (
    input  wire logic              UserCLK,
    input  wire logic              resetn,
    e_mem_bot_ctrl_if.slave        fab,
    output logic                   sram_en,
    output logic                   sram_we,
    output logic [ADDR_W-1:0]      sram_addr,
    output logic [31:0]            sram_wdata,
    input  wire logic [31:0]       sram_rdata
);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(RSP_DEPTH);
    localparam logic [PTR_W-1:0] C_LAST  = PTR_W'(RSP_DEPTH - 1);

    logic              s1_valid_q, s1_valid_d;
    logic              s1_we_q,    s1_we_d;
    logic              s1_err_q,   s1_err_d;
    logic [ADDR_W-1:0] s1_addr_q,  s1_addr_d;
    logic [31:0]       s1_wdata_q, s1_wdata_d;
    logic              s2_valid_q, s2_valid_d;
    logic              s2_err_q,   s2_err_d;
    logic              wr_err_q,   wr_err_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [32:0]       fifo_mem [RSP_DEPTH];

    logic w_req_ready, w_accept, w_acc_rd, w_oor, w_push, w_pop, w_rsp_valid;
    logic w_unused;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == C_LAST) ? '0 : p + 1'b1;
    endfunction

    // Byte-lane bits never affect the access or its error status.
    assign w_unused    = &{1'b0, fab.addr0[1:0]};
    assign w_req_ready = (outstanding_q < C_DEPTH);
    assign w_accept    = fab.req_valid && w_req_ready;
    assign w_acc_rd    = w_accept && !fab.req_we;
    assign w_oor       = |fab.addr0[31:ADDR_W+2];
    assign w_rsp_valid = (count_q != '0);
    assign w_pop       = w_rsp_valid && fab.rsp_ready;
    assign w_push      = s2_valid_q;

    always_comb begin
        s1_valid_d    = w_accept;
        s1_we_d       = w_accept && fab.req_we;
        s1_err_d      = w_accept && w_oor;
        s1_addr_d     = w_accept ? fab.addr0[ADDR_W+1:2] : s1_addr_q;
        s1_wdata_d    = w_accept ? fab.write_data : s1_wdata_q;
        s2_valid_d    = s1_valid_q && !s1_we_q;
        s2_err_d      = s1_valid_q && !s1_we_q && s1_err_q;
        wr_err_d      = wr_err_q || (s1_valid_q && s1_we_q && s1_err_q);
        outstanding_d = outstanding_q;
        count_d       = count_q;
        wr_ptr_d      = w_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d      = w_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        unique case ({w_acc_rd, w_pop})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
        unique case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q    <= 1'b0;
            s1_we_q       <= 1'b0;
            s1_err_q      <= 1'b0;
            s1_addr_q     <= '0;
            s1_wdata_q    <= '0;
            s2_valid_q    <= 1'b0;
            s2_err_q      <= 1'b0;
            wr_err_q      <= 1'b0;
            outstanding_q <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_we_q       <= s1_we_d;
            s1_err_q      <= s1_err_d;
            s1_addr_q     <= s1_addr_d;
            s1_wdata_q    <= s1_wdata_d;
            s2_valid_q    <= s2_valid_d;
            s2_err_q      <= s2_err_d;
            wr_err_q      <= wr_err_d;
            outstanding_q <= outstanding_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the empty count masks stale entries.
    always_ff @(posedge UserCLK) begin
        if (w_push) begin
            fifo_mem[wr_ptr_q] <= {(s2_err_q ? 32'h0 : sram_rdata), s2_err_q};
        end
    end

    assign sram_en       = s1_valid_q && !s1_err_q;
    assign sram_we       = s1_we_q;
    assign sram_addr     = s1_addr_q;
    assign sram_wdata    = s1_wdata_q;
    assign fab.req_ready = w_req_ready;
    assign fab.rsp_valid = w_rsp_valid;
    assign fab.read_data = w_rsp_valid ? fifo_mem[rd_ptr_q][32:1] : 32'h0;
    assign fab.rsp_err   = w_rsp_valid ? fifo_mem[rd_ptr_q][0] : 1'b0;
    assign fab.wr_err    = wr_err_q;
endmodule
`default_nettype wire

// File: tb/tb_e_mem_bot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_e_mem_bot_ctrl
// Brief    : Scoreboard bench for e_mem_bot_ctrl with a behavioural SRAM
// Revision : 1.0
// ============================================================================
module tb_e_mem_bot_ctrl;
    logic        clk = 1'b0;
    logic        resetn;
    logic        sram_en, sram_we;
    logic [9:0]  sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    e_mem_bot_ctrl_if bus ();

    e_mem_bot_ctrl #(.ADDR_W(10), .RSP_DEPTH(4)) dut (
        .UserCLK    (clk),
        .resetn     (resetn),
        .fab        (bus),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] smem    [1024];
    logic [31:0] ref_mem [1024];
    logic [32:0] sb_q [$];
    int n_checks = 0, n_pass = 0;
    int n_acc = 0, n_pops = 0, ready_drops = 0, cyc = 0;
    bit stream_mode = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sram_en) begin
            if (sram_we) smem[sram_addr] <= sram_wdata;
            else         sram_rdata      <= smem[sram_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Scoreboard: expectations pushed on accept, compared on pop.
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb_q.size() == 0) check_eq("rsp_unexpected", 64'(sb_q.size()), 64'd1);
                else begin
                    check_eq("rsp", {31'b0, bus.read_data, bus.rsp_err}, {31'b0, sb_q.pop_front()});
                    n_pops++;
                end
            end
            if (bus.req_valid && bus.req_ready) begin
                n_acc++;
                if (bus.req_we) begin
                    if (bus.addr0[31:12] == 20'h0) ref_mem[bus.addr0[11:2]] = bus.write_data;
                end else if (bus.addr0[31:12] != 20'h0) begin
                    sb_q.push_back(33'h1);
                end else begin
                    sb_q.push_back({ref_mem[bus.addr0[11:2]], 1'b0});
                end
            end
            if (stream_mode && bus.req_valid && !bus.req_ready) ready_drops++;
        end
    end

    // Called at posedge+#1; returns at posedge+#1 after the accept edge.
    task automatic send(input logic we, input logic [31:0] a, input logic [31:0] d);
        int waited = 0;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.addr0      = a;
        bus.write_data = d;
        @(negedge clk);
        while (!bus.req_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.req_ready) check_eq("req_timeout", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    int t0, p0, a0;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            smem[i]    = 32'hA500_0000 ^ (i * 32'h0001_0101);
            ref_mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0101);
        end
        resetn = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.addr0 = '0;
        bus.write_data = '0;  bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check_eq("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("rst_sram_en",   64'(sram_en),       64'd0);
        check_eq("rst_wr_err",    64'(bus.wr_err),    64'd0);
        check_eq("rst_read_data", 64'(bus.read_data), 64'd0);

        // Write then read the same address back to back
        step();
        bus.req_valid = 1'b1; bus.req_we = 1'b1;
        bus.addr0 = 32'h10; bus.write_data = 32'hDEAD_BEEF;
        step();
        bus.req_we = 1'b0; bus.write_data = '0;
        @(negedge clk);
        check_eq("wr_sram_en",    64'(sram_en),    64'd1);
        check_eq("wr_sram_we",    64'(sram_we),    64'd1);
        check_eq("wr_sram_addr",  64'(sram_addr),  64'd4);
        check_eq("wr_sram_wdata", 64'(sram_wdata), 64'hDEAD_BEEF);
        step();
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_eq("rd_sram_en",   64'(sram_en),   64'd1);
        check_eq("rd_sram_we",   64'(sram_we),   64'd0);
        check_eq("rd_sram_addr", 64'(sram_addr), 64'd4);
        @(negedge clk);
        check_eq("rd_lat_e1_valid", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        check_eq("rd_lat_e2_valid", 64'(bus.rsp_valid), 64'd1);
        check_eq("rd_data", 64'(bus.read_data), 64'hDEAD_BEEF);
        check_eq("rd_err",  64'(bus.rsp_err),   64'd0);
        repeat (3) step();

        // Streaming
        ready_drops = 0; t0 = cyc; p0 = n_pops; stream_mode = 1'b1;
        for (int i = 0; i < 100; i++) send(1'b0, 32'(i * 4), 32'h0);
        stream_mode = 1'b0;
        check_eq("stream_cycles", 64'(cyc - t0), 64'd100);
        repeat (4) step();
        check_eq("stream_pops", 64'(n_pops - p0), 64'd100);
        check_eq("stream_ready_drops", 64'(ready_drops), 64'd0);

        // Backpressure
        bus.rsp_ready = 1'b0; a0 = n_acc;
        bus.req_valid = 1'b1; bus.req_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.addr0 = 32'h400 + 32'((n_acc - a0) * 4);
            step();
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_eq("bp_accepts",   64'(n_acc - a0),   64'd4);
        check_eq("bp_req_ready", 64'(bus.req_ready), 64'd0);
        check_eq("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        step(); bus.rsp_ready = 1'b1;
        step(); bus.rsp_ready = 1'b0;
        @(negedge clk);
        check_eq("bp_recover_ready", 64'(bus.req_ready), 64'd1);
        check_eq("bp_sb_left", 64'(sb_q.size()), 64'd3);
        step(); bus.rsp_ready = 1'b1;
        repeat (5) step();
        check_eq("bp_drained", 64'(sb_q.size()), 64'd0);

        // Push and pop together as the last credit's data arrives
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b0, 32'h600 + 32'(i * 4), 32'h0);
        step(); bus.rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("pp_ready_full", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        check_eq("pp_ready_after", 64'(bus.req_ready), 64'd1);
        repeat (6) step();
        check_eq("pp_drained", 64'(sb_q.size()), 64'd0);

        // Out of range
        send(1'b0, 32'h1000, 32'h0);
        @(negedge clk);
        check_eq("oor_rd_sram_en", 64'(sram_en), 64'd0);
        repeat (3) step();
        check_eq("oor_wr_err_pre", 64'(bus.wr_err), 64'd0);
        send(1'b1, 32'h1000, 32'h1234_5678);
        @(negedge clk);
        check_eq("oor_wr_sram_en", 64'(sram_en), 64'd0);
        @(negedge clk);
        check_eq("oor_wr_err", 64'(bus.wr_err), 64'd1);
        repeat (5) step();
        check_eq("oor_wr_err_sticky", 64'(bus.wr_err), 64'd1);
        send(1'b0, 32'h0, 32'h0);
        repeat (4) step();

        // Reset mid-burst
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.addr0 = 32'h20;
        repeat (2) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        check_eq("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("mid_rst_sram_en",   64'(sram_en),       64'd0);
        check_eq("mid_rst_wr_err",    64'(bus.wr_err),    64'd0);
        bus.req_valid = 1'b0;
        sb_q.delete();
        step();
        resetn = 1'b1;
        @(negedge clk);
        check_eq("post_rst_req_ready", 64'(bus.req_ready), 64'd1);
        check_eq("post_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        step();
        bus.rsp_ready = 1'b1;
        send(1'b0, 32'h10, 32'h0);
        repeat (4) step();
        check_eq("final_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/e_mem_bot_ctrl.md
# e_mem_bot_ctrl

Memory access controller for the bottom east-edge memory tile. It sits directly downstream of the tile switch matrix, which drives it `addr0` and `write_data`, and it returns `read_data` back into the matrix. The controller turns fabric requests into accesses on a single-port synchronous SRAM macro and buffers read responses in a credit-guarded FIFO. Read responses therefore tolerate fabric backpressure, and no SRAM data is ever lost.

## Interface
Parameters:
- `ADDR_W`, 10: SRAM word-address width; the memory is 2^ADDR_W words of 32 bits.
- `RSP_DEPTH`, 4: response FIFO depth. Must be ≥ 4, which is the minimum for full read throughput.

Ports (one clock; reset is asynchronous and active-low):
- `UserCLK` in 1: fabric user clock; all state is on its rising edge.
- `resetn` in 1: asynchronous active-low reset.
- `addr0` in 32: byte address from the switch matrix. Word index is `addr0[ADDR_W+1:2]`.
- `write_data` in 32: write data from the switch matrix.
- `req_valid` in 1: request present.
- `req_we` in 1: 1 = write, 0 = read.
- `req_ready` out 1: request can be accepted.
- `read_data` out 32: head of the response FIFO, routed back to the switch matrix.
- `rsp_valid` out 1: response FIFO not empty.
- `rsp_err` out 1: the head response was an out-of-range read.
- `rsp_ready` in 1: fabric consumes the head response.
- `wr_err` out 1: sticky flag for an out-of-range write.
- `sram_en` out 1: SRAM access strobe.
- `sram_we` out 1: SRAM write strobe.
- `sram_addr` out ADDR_W: SRAM word address.
- `sram_wdata` out 32: SRAM write data.
- `sram_rdata` in 32: SRAM read data, valid the cycle after an `sram_en` read.

## Operation
- **Accept rule:** a request is accepted when `req_valid && req_ready`.
- **Out-of-range:** a request is out-of-range when `addr0[31:ADDR_W+2]` is nonzero. Bits [1:0] are ignored and are never an error.
- **Issue register (S1):** each accepted request is captured into S1 with fields valid, we, word address, wdata and err. S1 drives `sram_en = S1.valid && !S1.err`, `sram_we = S1.we`, `sram_addr`, `sram_wdata`. S1 is never stalled.
- **Write path:**
  - In range: the SRAM is written at the end of the S1 cycle. No response is generated.
  - Out of range: the SRAM is not accessed, `wr_err` is set to 1, and the flag stays set until reset.
- **Read path:**
  - S1 advances into S2 with fields valid and err.
  - In the S2 cycle, the FIFO is pushed with `{err ? 32'h0 : sram_rdata, err}`.
  - An out-of-range read makes no SRAM access but still produces a response: data 0, `rsp_err = 1`.
- **Credit counter `outstanding`:** range 0..RSP_DEPTH.
  - +1 on every accepted read.
  - −1 on every pop (`rsp_valid && rsp_ready`).
  - Both in the same cycle: no net change.
  - Writes never count.
- **Ready:** `req_ready = (outstanding < RSP_DEPTH)`. It is driven from registers only, with no combinational path from `rsp_ready` or `req_valid`. It gates writes as well as reads.
- **FIFO:**
  - Circular buffer with wrapping read/write pointers.
  - Push and pop in the same cycle are legal, including on a full FIFO with a pop.
  - The credit scheme guarantees a push never meets a full FIFO without a pop, so no overflow is possible.
  - With `rsp_valid = 0`, `read_data` and `rsp_err` are 0.
- **Ordering:** responses return in request order. A write followed by a read of the same address returns the new data.
- **Reset:**
  - Outputs: `req_ready` is 1 after release; every other output is 0.
  - State: S1/S2 are invalid, the FIFO is empty, and `outstanding = 0`.
  - Assertion mid-operation drops all in-flight requests and buffered responses immediately, and drives `sram_en` low at once.

## Timing
- **Accept to SRAM:** a request accepted at edge E0 drives the SRAM in cycle E0→E1. A write lands at E1.
- **Read latency:** `sram_rdata` is valid in cycle E1→E2 and is pushed at E2. `rsp_valid` is high from E2, so latency is 2 cycles from the accept edge to the first cycle of `rsp_valid`. Out-of-range reads have the same latency.
- **Throughput:** sustained 1 request/cycle with `rsp_ready` held 1.
- **Backpressure:** with `rsp_ready` low, at most RSP_DEPTH reads can be accepted. `req_ready` falls on the edge that makes `outstanding = RSP_DEPTH`.
- **Recovery:** `req_ready` returns high the cycle after the first pop.

## Test plan
- **Reset:** assert `resetn=0` mid-burst → `rsp_valid=0`, `sram_en=0`, `wr_err=0` immediately. After release, `req_ready=1`.
- **Write then read:** write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 back-to-back with `rsp_ready=1` → `sram_addr=4` for both. `read_data=0xDEADBEEF` with `rsp_err=0`, `rsp_valid` 2 cycles after the read accept.
- **Streaming:** 100 consecutive reads at addresses 0..99 with `rsp_ready=1` → `req_ready` never drops, responses arrive in order, one per cycle.
- **Backpressure:** `rsp_ready=0`, issue reads continuously → exactly 4 accepted, `req_ready=0`. Raise `rsp_ready` for 1 cycle → one pop, `req_ready=1` the next cycle, no data lost or reordered.
- **Out of range (default ADDR_W=10):**
  - Read 0x0000_1000 → `sram_en` stays 0, response has `read_data=0` and `rsp_err=1`.
  - Write 0x0000_1000 → `wr_err=1` and stays 1, memory unchanged.
- **Push/pop on full FIFO:** FIFO full (4 entries), `outstanding=4`, pop on the same cycle as the last in-flight push → count stays consistent, entries wrap correctly, order preserved.
